// File: rtl/fle_fabric_pkg.sv
// fle_fabric_pkg: shared constants for the fle fabric register bank.
package fle_fabric_pkg;

    localparam int CFG_BITS_PER_FF = 3;

    localparam logic [1:0] D_LUT    = 2'd0;
    localparam logic [1:0] D_CHAIN  = 2'd1;
    localparam logic [1:0] D_HOLD   = 2'd2;
    localparam logic [1:0] D_TOGGLE = 2'd3;

endpackage

// File: rtl/fle_fabric_ff_slice.sv
// fle_fabric_ff_slice: one flip-flop with D-source mux, scan/enable priority and output mux.
module fle_fabric_ff_slice
    import fle_fabric_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       cfg_en_i,
    input  logic       test_en_i,
    input  logic       ce_i,
    input  logic       sc_in_i,
    input  logic       chain_in_i,
    input  logic       lut_i,
    input  logic       out_sel_i,
    input  logic [1:0] d_sel_i,
    output logic       q_o,
    output logic       out_o
);

    logic q_q, q_d, d_fn;

    always_comb begin
        d_fn = d_sel_i == D_LUT   ? lut_i      :
               d_sel_i == D_CHAIN ? chain_in_i :
               d_sel_i == D_HOLD  ? q_q        : ~q_q;
        q_d  = cfg_en_i  ? q_q     :
               test_en_i ? sc_in_i :
               ce_i      ? d_fn    : q_q;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) q_q <= 1'b0;
        else          q_q <= q_d;
    end

    // Outputs are forced low while configuring so half-loaded selects never reach routing.
    assign q_o   = q_q;
    assign out_o = cfg_en_i ? 1'b0 : (out_sel_i ? q_q : lut_i);

endmodule

// File: rtl/fle_fabric_reg_bank.sv
// fle_fabric_reg_bank: NUM_FF configurable register slices with config chain,
// load counter and scan chain.
module fle_fabric_reg_bank
    import fle_fabric_pkg::*;
#(
    parameter int NUM_FF = 2
) (
    input  logic              fabric_clk,
    input  logic              fabric_reset_n,
    input  logic              cfg_en,
    input  logic              ccff_head,
    output logic              ccff_tail,
    output logic              cfg_done,
    input  logic              Test_en,
    input  logic              fabric_sc_in,
    output logic              fabric_sc_out,
    input  logic              fabric_ce,
    input  logic [NUM_FF-1:0] frac_out,
    input  logic              fabric_reg_in,
    output logic              fabric_reg_out,
    output logic [NUM_FF-1:0] fabric_out
);

    localparam int CFG_LEN = CFG_BITS_PER_FF * NUM_FF;
    localparam int CW      = $clog2(CFG_LEN + 1);

    logic [CFG_LEN-1:0] cfg_q, cfg_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               done_q, done_d;
    logic [NUM_FF-1:0]  q;

    always_comb begin
        cfg_d  = cfg_en ? {cfg_q[CFG_LEN-2:0], ccff_head} : cfg_q;
        cnt_d  = (cfg_en && cnt_q != CW'(CFG_LEN)) ? cnt_q + 1'b1 : cnt_q;
        done_d = cnt_d == CW'(CFG_LEN);
    end

    always_ff @(posedge fabric_clk or negedge fabric_reset_n) begin
        if (!fabric_reset_n) begin
            cfg_q  <= '0;
            cnt_q  <= '0;
            done_q <= 1'b0;
        end else begin
            cfg_q  <= cfg_d;
            cnt_q  <= cnt_d;
            done_q <= done_d;
        end
    end

    assign ccff_tail      = cfg_q[CFG_LEN-1];
    assign cfg_done       = done_q;
    assign fabric_sc_out  = q[NUM_FF-1];
    assign fabric_reg_out = q[NUM_FF-1];

    for (genvar i = 0; i < NUM_FF; i++) begin : g_slice
        localparam int B = CFG_BITS_PER_FF * i;
        logic chain_in, scan_in;
        if (i == 0) begin : g_head
            assign chain_in = fabric_reg_in;
            assign scan_in  = fabric_sc_in;
        end else begin : g_link
            assign chain_in = q[i-1];
            assign scan_in  = q[i-1];
        end
        fle_fabric_ff_slice u_slice (
            .clk_i      (fabric_clk),
            .rst_n_i    (fabric_reset_n),
            .cfg_en_i   (cfg_en),
            .test_en_i  (Test_en),
            .ce_i       (fabric_ce),
            .sc_in_i    (scan_in),
            .chain_in_i (chain_in),
            .lut_i      (frac_out[i]),
            .out_sel_i  (cfg_q[B]),
            .d_sel_i    ({cfg_q[B+1], cfg_q[B+2]}),
            .q_o        (q[i]),
            .out_o      (fabric_out[i])
        );
    end

endmodule

// File: tb/tb_fle_fabric_reg_bank.sv
// tb_fle_fabric_reg_bank: directed checks of the fle register bank with NUM_FF=2.
module tb_fle_fabric_reg_bank;

    logic       clk = 1'b0;
    logic       rst_n, cfg_en, ccff_head, test_en, sc_in, ce, reg_in;
    logic [1:0] frac;
    logic       ccff_tail, cfg_done, sc_out, reg_out;
    logic [1:0] fout;
    int         n_chk = 0;
    int         n_fail = 0;

    fle_fabric_reg_bank #(.NUM_FF(2)) dut (
        .fabric_clk     (clk),
        .fabric_reset_n (rst_n),
        .cfg_en         (cfg_en),
        .ccff_head      (ccff_head),
        .ccff_tail      (ccff_tail),
        .cfg_done       (cfg_done),
        .Test_en        (test_en),
        .fabric_sc_in   (sc_in),
        .fabric_sc_out  (sc_out),
        .fabric_ce      (ce),
        .frac_out       (frac),
        .fabric_reg_in  (reg_in),
        .fabric_reg_out (reg_out),
        .fabric_out     (fout)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic shift(input logic b);
        cfg_en = 1'b1;
        ccff_head = b;
        tick();
    endtask

    initial begin
        logic [5:0] seq;
        rst_n = 1'b0; cfg_en = 1'b0; ccff_head = 1'b0; test_en = 1'b0;
        sc_in = 1'b0; ce = 1'b0; reg_in = 1'b0; frac = 2'b10;
        #2;
        chk("rst_q1", {7'd0, reg_out}, 8'd0);
        chk("rst_scout", {7'd0, sc_out}, 8'd0);
        chk("rst_done", {7'd0, cfg_done}, 8'd0);
        chk("rst_tail", {7'd0, ccff_tail}, 8'd0);
        chk("rst_fout", {6'd0, fout}, 8'h2);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Load slice0 {out_sel=1,d_sel=0}, slice1 {out_sel=1,d_sel=1}; first bit ends in cfg[5].
        seq = 6'b101001;
        for (int k = 5; k >= 0; k--) begin
            shift(seq[k]);
            chk("cfg_fout_zero", {6'd0, fout}, 8'd0);
            if (k == 1) chk("done_after5", {7'd0, cfg_done}, 8'd0);
        end
        chk("done_after6", {7'd0, cfg_done}, 8'd1);
        chk("tail_first_bit", {7'd0, ccff_tail}, 8'd1);
        cfg_en = 1'b0;
        ce = 1'b1;
        frac = 2'b01;
        #1;
        chk("reg_path_q0", {6'd0, fout}, 8'h0);
        tick();
        chk("lut_edge1", {6'd0, fout}, 8'h1);
        tick();
        chk("chain_edge2", {6'd0, fout}, 8'h3);
        chk("reg_out_edge2", {7'd0, reg_out}, 8'd1);

        // Reconfigure slice0 to toggle while Test_en is also high: FFs must hold.
        ce = 1'b0;
        test_en = 1'b1;
        sc_in = 1'b0;
        seq = 6'b101111;
        for (int k = 5; k >= 0; k--) shift(seq[k]);
        chk("done_sticky", {7'd0, cfg_done}, 8'd1);
        cfg_en = 1'b0;
        test_en = 1'b0;
        #1;
        chk("cfg_beats_scan", {6'd0, fout}, 8'h3);
        ce = 1'b1;
        tick();
        chk("toggle1", {6'd0, fout}, 8'h2);
        tick();
        chk("toggle2", {6'd0, fout}, 8'h1);
        tick();
        chk("toggle3", {6'd0, fout}, 8'h2);
        ce = 1'b0;
        tick();
        chk("ce_hold", {6'd0, fout}, 8'h2);

        test_en = 1'b1;
        sc_in = 1'b1;
        tick();
        chk("scan1", {6'd0, fout}, 8'h1);
        sc_in = 1'b0;
        tick();
        chk("scan2", {6'd0, fout}, 8'h2);
        chk("scan_out", {7'd0, sc_out}, 8'd1);
        test_en = 1'b0;

        // Reset mid-load clears cfg, counter and done.
        for (int k = 0; k < 3; k++) shift(1'b1);
        chk("tail_pre_rst", {7'd0, ccff_tail}, 8'd1);
        rst_n = 1'b0;
        cfg_en = 1'b0;
        #1;
        chk("rst_mid_done", {7'd0, cfg_done}, 8'd0);
        chk("rst_mid_tail", {7'd0, ccff_tail}, 8'd0);
        chk("rst_mid_fout", {6'd0, fout}, 8'h1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            shift(1'b0);
            if (k == 4) chk("reload_after5", {7'd0, cfg_done}, 8'd0);
        end
        chk("reload_after6", {7'd0, cfg_done}, 8'd1);
        cfg_en = 1'b0;
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
